decode_print_queue: RTL and testbench
=====================================

DECODE_PRINT_QUEUE -- requirements
Module: decode_print_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count (power of 2, 2..64).
REQ-002 SHALL have port clk, input, 1, sole clock (all logic on rising edge).
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, decoder offers an instruction.
REQ-005 SHALL have port in_ready, output, 1, queue accepts this cycle.
REQ-006 SHALL have port in_ins, input, fat_instruction_t, decoded instruction.
REQ-007 SHALL have port in_pc, input, 64, address of the instruction's first byte.
REQ-008 SHALL have port in_len, input, 4, instruction length in bytes (1..15).
REQ-009 SHALL have port flush, input, 1, discard all entries.
REQ-010 SHALL have port out_valid, output, 1, head entry presented to the printer.
REQ-011 SHALL have port out_ready, input, 1, printer consumes the head this cycle.
REQ-012 SHALL have port out_ins, output, fat_instruction_t, head instruction.
REQ-013 SHALL have port out_pc, output, 64, head PC.
REQ-014 SHALL have port out_seq, output, 32, head sequence number.
REQ-015 SHALL have port out_gap, output, 1, head PC differs from predecessor PC+len.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-017 SHALL push when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), independent of out_ready; no pass-through when full.
REQ-019 SHALL drive out_valid = (count != 0), with out_* read combinationally from the head slot.
REQ-020 SHALL have push-to-out_valid latency of exactly 1 cycle; no bypass when empty.
REQ-021 SHALL allow simultaneous push and pop when 0 < count < DEPTH, leaving count unchanged.
REQ-022 SHALL use read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-023 SHALL tag each pushed entry with seq_next, then increment seq_next modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-024 SHALL hold expected_pc = in_pc + in_len (64-bit, carry discarded) of the last push, plus flag have_prev.
REQ-025 SHALL store gap = have_prev && (in_pc != expected_pc) per entry; the first push after reset or flush has gap = 0.
REQ-026 SHALL, on flush, zero count and both pointers and clear have_prev in the next cycle; a push or pop in the flush cycle is discarded.
REQ-027 SHALL NOT reset seq_next on flush.
REQ-028 SHALL hold out_* stable while out_valid && !out_ready.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear: pointers, count, seq_next, have_prev, expected_pc, statistics counters.
REQ-030 SHALL show after reset: in_ready=1, out_valid=0, count=0; out_ins/out_pc/out_seq/out_gap = 0.
REQ-031 SHALL leave the entry storage array unreset; outputs are masked to 0 while empty.

Configuration
REQ-032 SHALL use macro DECODE_PRINT_QUEUE_STATS_EN.
REQ-033 SHALL, when it is defined, add outputs stat_pushed (32), stat_full_stall (32), stat_gaps (32), all saturating at 0xFFFFFFFF and not cleared by flush.
REQ-034 SHALL count as follows: stat_pushed per push, stat_full_stall per cycle with in_valid && !in_ready, stat_gaps per push with gap = 1.
REQ-035 SHALL, when the macro is undefined, have no stat_* ports or logic, with all other behaviour identical.

Structure
REQ-036 SHALL put dpq_entry_t (ins, pc, seq, gap) in package DecoderTypes, next to fat_instruction_t.
REQ-037 SHALL have one sub-module, dpq_storage: DEPTH x dpq_entry_t array with one write port and one combinational read port.
REQ-038 SHALL keep pointers, count, sequence, gap and stats logic in decode_print_queue.

Verification
REQ-039 SHALL cover fill: 8 pushes with out_ready=0 -> count=8, in_ready=0, 9th in_valid is held; stats build gives stat_full_stall=1 per stalled cycle.
REQ-040 SHALL cover order: push pc 0x1000 len 3, then 0x1003 len 2, then drain -> out_seq 0,1 with out_gap 0,0 in order.
REQ-041 SHALL cover gap: push 0x1000 len 3, then 0x2000 -> second entry has out_gap=1; stat_gaps=1.
REQ-042 SHALL cover flush: flush with count=5 and in_valid=1 -> next cycle count=0, out_valid=0; next push gets seq 5 and gap=0.
REQ-043 SHALL cover wrap: preload seq_next=0xFFFFFFFF, then push 20 with random push/pop -> seq runs 0xFFFFFFFF, 0, 1...; order is kept across pointer wrap.
REQ-044 SHALL cover reset mid-operation: reset_n low with count=3 -> count=0, in_ready=1, out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_print_queue_pkg.sv
// ---------------------------------------------------------------------------
// DecoderTypes: shared types for the decode -> print instruction queue.
//   fat_instruction_t : decoded instruction record produced by the decoder
//   dpq_entry_t       : one queue slot (instruction, PC, sequence tag, gap flag)
//   sat_inc32         : saturating 32-bit increment used by statistics counters
// ---------------------------------------------------------------------------
package DecoderTypes;

  typedef struct packed {
    logic [15:0] opcode;
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [31:0] imm;
  } fat_instruction_t;

  typedef struct packed {
    fat_instruction_t ins;
    logic [63:0]      pc;
    logic [31:0]      seq;
    logic             gap;
  } dpq_entry_t;

  // Sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dpq_storage.sv
// ---------------------------------------------------------------------------
// dpq_storage: DEPTH x dpq_entry_t slot array for decode_print_queue.
// One synchronous write port, one combinational read port. The array holds
// no reset; the owner masks the read data while the queue is empty.
// Ports:
//   clk    - clock (rising edge)
//   we     - write enable
//   waddr  - write slot index
//   wdata  - entry to write
//   raddr  - read slot index
//   rdata  - entry at raddr (combinational)
// ---------------------------------------------------------------------------
module dpq_storage
  import DecoderTypes::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  dpq_entry_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output dpq_entry_t                 rdata
);

  dpq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_print_queue.sv
// ---------------------------------------------------------------------------
// decode_print_queue: FIFO between the instruction decoder and the printer.
// Each accepted instruction is tagged with a running 32-bit sequence number
// and a gap flag that marks a PC discontinuity relative to the previously
// pushed instruction (pc != previous pc + previous len).
//
// Optional feature: define DECODE_PRINT_QUEUE_STATS_EN to add saturating
// statistics outputs stat_pushed, stat_full_stall and stat_gaps.
//
// Ports:
//   clk, reset_n          - clock; asynchronous active-low reset
//   in_valid/in_ready     - decoder handshake; in_ready = (count < DEPTH)
//   in_ins, in_pc, in_len - decoded instruction, its PC and byte length
//   flush                 - drop all entries (push/pop in that cycle ignored)
//   out_valid/out_ready   - printer handshake; out_valid = (count != 0)
//   out_ins/pc/seq/gap    - head entry, forced to 0 while empty
//   count                 - current occupancy
//   stat_*                - statistics (only with DECODE_PRINT_QUEUE_STATS_EN)
// ---------------------------------------------------------------------------
module decode_print_queue
  import DecoderTypes::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fat_instruction_t         in_ins,
  input  logic [63:0]              in_pc,
  input  logic [3:0]               in_len,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fat_instruction_t         out_ins,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_seq,
  output logic                     out_gap,
  output logic [$clog2(DEPTH):0]   count
`ifdef DECODE_PRINT_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_pushed,
  output logic [31:0]              stat_full_stall,
  output logic [31:0]              stat_gaps
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic [31:0]   seq_next;
  logic [63:0]   expected_pc;
  logic          have_prev;

  logic          do_push;
  logic          do_pop;
  logic          entry_gap;
  dpq_entry_t    wr_entry;
  dpq_entry_t    head;

  assign in_ready  = (count_reg < CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  // A flush cycle swallows both handshakes so the queue comes out truly empty.
  assign do_push = in_valid && in_ready && !flush;
  assign do_pop  = out_valid && out_ready && !flush;

  assign entry_gap = have_prev && (in_pc != expected_pc);

  assign wr_entry = '{ins: in_ins, pc: in_pc, seq: seq_next, gap: entry_gap};

  dpq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is never reset, so hide stale slot contents while empty.
  assign out_ins = out_valid ? head.ins : '0;
  assign out_pc  = out_valid ? head.pc  : '0;
  assign out_seq = out_valid ? head.seq : '0;
  assign out_gap = out_valid ? head.gap : 1'b0;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Sequence tag survives flush; PC-continuity tracking does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_next    <= '0;
      expected_pc <= '0;
      have_prev   <= 1'b0;
    end else if (flush) begin
      have_prev <= 1'b0;
    end else if (do_push) begin
      seq_next    <= seq_next + 32'd1;
      expected_pc <= in_pc + 64'(in_len);
      have_prev   <= 1'b1;
    end
  end

`ifdef DECODE_PRINT_QUEUE_STATS_EN
  // Statistics are cleared only by reset, never by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pushed     <= '0;
      stat_full_stall <= '0;
      stat_gaps       <= '0;
    end else begin
      if (do_push) begin
        stat_pushed <= sat_inc32(stat_pushed);
      end
      if (in_valid && !in_ready) begin
        stat_full_stall <= sat_inc32(stat_full_stall);
      end
      if (do_push && entry_gap) begin
        stat_gaps <= sat_inc32(stat_gaps);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_print_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_print_queue: self-checking bench for decode_print_queue.
// A queue-based reference model tracks expected entries; every cycle the
// bench compares occupancy, handshakes and the head entry against it, plus
// hand-derived values from a vector table and directed corner sequences.
// Build with DECODE_PRINT_QUEUE_STATS_EN to also check the statistics.
// ---------------------------------------------------------------------------
module tb_decode_print_queue;
  import DecoderTypes::*;

  localparam int DEPTH = 8;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  fat_instruction_t in_ins;
  logic [63:0]      in_pc;
  logic [3:0]       in_len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  fat_instruction_t out_ins;
  logic [63:0]      out_pc;
  logic [31:0]      out_seq;
  logic             out_gap;
  logic [3:0]       count;
`ifdef DECODE_PRINT_QUEUE_STATS_EN
  logic [31:0]      stat_pushed;
  logic [31:0]      stat_full_stall;
  logic [31:0]      stat_gaps;
`endif

  decode_print_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .in_pc     (in_pc),
    .in_len    (in_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .out_seq   (out_seq),
    .out_gap   (out_gap),
    .count     (count)
`ifdef DECODE_PRINT_QUEUE_STATS_EN
    ,
    .stat_pushed     (stat_pushed),
    .stat_full_stall (stat_full_stall),
    .stat_gaps       (stat_gaps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    fat_instruction_t ins;
    logic [63:0]      pc;
    logic [31:0]      seq;
    logic             gap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_seq;
  logic [63:0] m_exp_pc;
  bit          m_have_prev;
  int          m_pushed;
  int          m_stall;
  int          m_gaps;

  int n_checks;
  int n_fail;

  // Vector table: inputs for one cycle plus hand-derived observations
  // during that cycle (-1 = don't care).
  typedef struct {
    bit          v;
    logic [63:0] pc;
    logic [3:0]  len;
    bit          ordy;
    bit          fl;
    int          exp_cnt;
    int          exp_seq;
    int          exp_gap;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fat_instruction_t rand_ins();
    fat_instruction_t r;
    r = {$urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_seq       = '0;
    m_exp_pc    = '0;
    m_have_prev = 1'b0;
    m_pushed    = 0;
    m_stall     = 0;
    m_gaps      = 0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_pc     = '0;
    in_len    = '0;
    in_ins    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model.
  task automatic cycle(input bit v, input logic [63:0] pc, input logic [3:0] len,
                       input bit ordy, input bit fl,
                       input int exp_cnt, input int exp_seq, input int exp_gap,
                       output bit pushed);
    exp_t e;
    bit   push;
    bit   pop;
    int   mc;
    in_valid  = v;
    in_pc     = pc;
    in_len    = len;
    in_ins    = rand_ins();
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    mc = sb.size();
    if (exp_cnt >= 0) chk("count_tbl", count, exp_cnt);
    if (exp_seq >= 0) chk("seq_tbl", out_seq, exp_seq);
    if (exp_gap >= 0) chk("gap_tbl", out_gap, exp_gap);
    chk("count", count, mc);
    chk("in_ready", in_ready, mc < DEPTH);
    chk("out_valid", out_valid, mc != 0);
    if (mc != 0) begin
      chk("out_seq", out_seq, sb[0].seq);
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_gap", out_gap, sb[0].gap);
      chk("out_ins", out_ins, sb[0].ins);
    end else begin
      chk("empty_out_zero", {out_ins, out_pc, out_seq, out_gap}, '0);
    end
    push = v && (mc < DEPTH) && !fl;
    pop  = (mc != 0) && ordy && !fl;
    if (v && mc >= DEPTH) m_stall++;
    if (pop) begin
      e = sb.pop_front();
      $display("pop  seq=%h pc=%h gap=%0d", e.seq, e.pc, e.gap);
    end
    if (push) begin
      e.ins = in_ins;
      e.pc  = pc;
      e.seq = m_seq;
      e.gap = m_have_prev && (pc != m_exp_pc);
      sb.push_back(e);
      $display("push seq=%h pc=%h gap=%0d", e.seq, e.pc, e.gap);
      m_seq       = m_seq + 32'd1;
      m_exp_pc    = pc + 64'(len);
      m_have_prev = 1'b1;
      m_pushed++;
      if (e.gap) m_gaps++;
    end
    if (fl) begin
      sb.delete();
      m_have_prev = 1'b0;
      $display("flush");
    end
    pushed = push;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    bit p;
    for (int i = 0; i < 3 * DEPTH && sb.size() > 0; i++) begin
      cycle(1'b0, 64'h0, 4'd0, 1'b1, 1'b0, -1, -1, -1, p);
    end
    @(negedge clk);
    chk("drained_count", count, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef DECODE_PRINT_QUEUE_STATS_EN
    chk("stat_pushed", stat_pushed, m_pushed);
    chk("stat_full_stall", stat_full_stall, m_stall);
    chk("stat_gaps", stat_gaps, m_gaps);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit p;
    int pushes;
    n_checks = 0;
    n_fail   = 0;

    // order (0x1000/0x1003 contiguous), gap (0x2000), simultaneous push/pop
    tbl[0]  = '{1, 64'h1000, 4'd3, 0, 0, 0, -1, -1};
    tbl[1]  = '{1, 64'h1003, 4'd2, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 64'h2000, 4'd4, 0, 0, 2, 0, 0};
    tbl[3]  = '{0, 64'h0,    4'd0, 1, 0, 3, 0, 0};
    tbl[4]  = '{0, 64'h0,    4'd0, 1, 0, 2, 1, 0};
    tbl[5]  = '{0, 64'h0,    4'd0, 1, 0, 1, 2, 1};
    tbl[6]  = '{0, 64'h0,    4'd0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 64'h2004, 4'd1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 64'h2005, 4'd1, 1, 0, 1, 3, 0};
    tbl[9]  = '{0, 64'h0,    4'd0, 1, 0, 1, 4, 0};
    tbl[10] = '{0, 64'h0,    4'd0, 0, 0, 0, -1, -1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_outs", {out_ins, out_pc, out_seq, out_gap}, '0);
    @(posedge clk);
    #1;

    // Vector table
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].pc, tbl[i].len, tbl[i].ordy, tbl[i].fl,
            tbl[i].exp_cnt, tbl[i].exp_seq, tbl[i].exp_gap, p);
    end
    check_stats();

    // Fill: 8 pushes, 9th held while full, then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 64'h3000 + 64'(4 * i), 4'd4, 1'b0, 1'b0, i, -1, -1, p);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'h3020, 4'd4, 1'b0, 1'b0, DEPTH, 0, -1, p);
    end
    cycle(1'b1, 64'h3020, 4'd4, 1'b1, 1'b0, DEPTH, 0, -1, p);
    chk("full_no_passthru", p, 1'b0);
    cycle(1'b1, 64'h3020, 4'd4, 1'b1, 1'b0, DEPTH - 1, 1, -1, p);
    check_stats();
    idle_drain();

    // Flush with count=5 and in_valid=1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'h4000 + 64'(4 * i), 4'd4, 1'b0, 1'b0, i, -1, -1, p);
    end
    cycle(1'b1, 64'h5000, 4'd2, 1'b1, 1'b1, 5, 0, -1, p);
    cycle(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 0, 0, 0, p);
    cycle(1'b1, 64'h9000, 4'd1, 1'b0, 1'b0, 0, -1, -1, p);
    cycle(1'b0, 64'h0, 4'd0, 1'b1, 1'b0, 1, 5, 0, p);
    check_stats();

    // Reset mid-operation: count falls to 0 without a clock edge
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'h6000 + 64'(2 * i), 4'd2, 1'b0, 1'b0, i, -1, -1, p);
    end
    chk("pre_rst_count", count, 3);
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    do_reset();

    // Sequence wrap and pointer wrap under random traffic
    do_reset();
    force dut.seq_next = 32'hFFFF_FFFF;
    #1;
    release dut.seq_next;
    m_seq  = 32'hFFFF_FFFF;
    pushes = 0;
    for (int c = 0; c < 400 && pushes < 20; c++) begin
      cycle(1'($urandom_range(0, 1)), 64'h7000 + 64'(3 * pushes) + 64'($urandom_range(0, 3) == 0),
            4'd3, 1'($urandom_range(0, 1)), 1'b0, -1, -1, -1, p);
      if (p) pushes++;
    end
    chk("wrap_push_budget", pushes >= 20, 1'b1);
    idle_drain();
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
